// File: rtl/click_decoder.sv
// Groups debounced key presses that arrive within a time window into single click events
// (1..MAX_CLICKS). Define CLICK_FIFO_EN to queue events in a FIFO instead of one holding slot.
module click_decoder #(
  parameter int WINDOW_CNT = 15_000_000,
  parameter int CNT_WIDTH  = 24,
  parameter int MAX_CLICKS = 3
`ifdef CLICK_FIFO_EN
  ,
  parameter int FIFO_DEPTH = 4
`endif
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            key_pulse,
  output logic                            evt_valid,
  output logic [$clog2(MAX_CLICKS+1)-1:0] evt_clicks,
  input  logic                            evt_ready,
  output logic                            evt_overflow,
  output logic                            busy
);

  localparam int CW = $clog2(MAX_CLICKS + 1);
  localparam logic [CNT_WIDTH-1:0] LP_TIMER_LAST = CNT_WIDTH'(WINDOW_CNT - 1);
  localparam logic [CW-1:0]        LP_MAX_CLICKS = CW'(MAX_CLICKS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_timer;
  logic [CW-1:0]        r_clicks;
  logic [CW-1:0]        w_clicks_inc;
  logic                 w_emit;
  logic [CW-1:0]        w_emit_clicks;
  logic                 r_overflow;

  assign w_clicks_inc = r_clicks + CW'(1);
  assign busy         = (r_state == ST_COUNT);
  assign evt_overflow = r_overflow;

  // Emit decision; the event itself is registered into the output stage one cycle later.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_emit        = 1'b0;
    w_emit_clicks = '0;
    case (r_state)
      ST_IDLE: begin
        if (key_pulse && (MAX_CLICKS == 1)) begin
          w_emit        = 1'b1;
          w_emit_clicks = LP_MAX_CLICKS;
        end
      end
      ST_COUNT: begin
        if (key_pulse) begin
          if (w_clicks_inc >= LP_MAX_CLICKS) begin
            w_emit        = 1'b1;
            w_emit_clicks = LP_MAX_CLICKS;
          end
        end else if (r_timer == LP_TIMER_LAST) begin
          w_emit        = 1'b1;
          w_emit_clicks = r_clicks;
        end
      end
      default: begin
        w_emit        = 1'b0;
        w_emit_clicks = '0;
      end
    endcase
  end

  // A press on the expiry cycle wins over the timeout: it is counted and the window restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_clicks <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (key_pulse && (MAX_CLICKS != 1)) begin
            r_state  <= ST_COUNT;
            r_clicks <= CW'(1);
          end else begin
            r_clicks <= '0;
          end
        end
        ST_COUNT: begin
          if (key_pulse) begin
            r_timer <= '0;
            if (w_clicks_inc >= LP_MAX_CLICKS) begin
              r_state  <= ST_IDLE;
              r_clicks <= '0;
            end else begin
              r_clicks <= w_clicks_inc;
            end
          end else if (r_timer == LP_TIMER_LAST) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_clicks <= '0;
          end else begin
            r_timer <= r_timer + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_timer  <= '0;
          r_clicks <= '0;
        end
      endcase
    end
  end

`ifdef CLICK_FIFO_EN

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_push  = w_emit && (!w_full || w_pop);

  assign evt_valid  = !w_empty;
  assign evt_clicks = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; entries are only observable between the
  // pointers, and the pointers themselves are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_emit_clicks;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_emit && !w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

`else

  logic          r_evt_valid;
  logic [CW-1:0] r_evt_clicks;
  logic          w_pop;
  logic          w_slot_free;

  assign w_pop       = r_evt_valid && evt_ready;
  assign w_slot_free = !r_evt_valid || evt_ready;

  assign evt_valid  = r_evt_valid;
  assign evt_clicks = r_evt_clicks;

  // A pop and a load in the same cycle keep evt_valid high with the new event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_evt_valid  <= 1'b0;
      r_evt_clicks <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= w_emit && !w_slot_free;
      if (w_emit && w_slot_free) begin
        r_evt_valid  <= 1'b1;
        r_evt_clicks <= w_emit_clicks;
      end else if (w_pop) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

`endif

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder: expected events and overflow pulses are queued as
// stimulus is applied and matched against handshakes observed on the DUT outputs.
module tb_click_decoder;

  localparam int WIN  = 20;
  localparam int MAXC = 3;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b0;
  logic          key_pulse = 1'b0;
  logic          evt_ready = 1'b0;
  logic          evt_valid;
  logic [CW-1:0] evt_clicks;
  logic          evt_overflow;
  logic          busy;

  typedef struct {
    int clicks;
    int cyc;
  } exp_evt_t;

  exp_evt_t q_evt[$];
  int       q_ovf[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc     = 0;
  int       t0      = 0;

  click_decoder #(
    .WINDOW_CNT(WIN),
    .CNT_WIDTH (24),
    .MAX_CLICKS(MAXC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_pulse   (key_pulse),
    .evt_valid   (evt_valid),
    .evt_clicks  (evt_clicks),
    .evt_ready   (evt_ready),
    .evt_overflow(evt_overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: drive inputs for this cycle, score outputs, advance one cycle.
  task automatic step(input logic kp, input logic rdy);
    exp_evt_t e;
    key_pulse = kp;
    evt_ready = rdy;
    #1;
    if (evt_valid && evt_ready) begin
      if (q_evt.size() == 0) begin
        check("evt_unexpected", {31'd0, evt_valid}, 32'd0);
      end else begin
        e = q_evt.pop_front();
        check("evt_clicks", {{(32-CW){1'b0}}, evt_clicks}, e.clicks);
        check("evt_cycle", cyc - t0, e.cyc);
      end
    end
    if (evt_overflow) begin
      if (q_ovf.size() == 0) check("ovf_unexpected", {31'd0, evt_overflow}, 32'd0);
      else                   check("ovf_cycle", cyc - t0, q_ovf.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_seq(input int p0, input int p1, input int p2, input int p3,
                         input int len, input logic rdy);
    for (int i = 0; i < len; i++) begin
      step((i == p0) || (i == p1) || (i == p2) || (i == p3), rdy);
    end
  endtask

  task automatic push_evt(input int clicks, input int rel_cyc);
    exp_evt_t e;
    e.clicks = clicks;
    e.cyc    = rel_cyc;
    q_evt.push_back(e);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_evt_q_empty"}, q_evt.size(), 0);
    check({tag, "_ovf_q_empty"}, q_ovf.size(), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'd0, evt_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_clicks"}, {{(32-CW){1'b0}}, evt_clicks}, 32'd0);
    check({tag, "_ovf"}, {31'd0, evt_overflow}, 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single press: busy for cycles 1..20, event at cycle 21 only
    t0 = cyc;
    push_evt(1, 21);
    for (int i = 0; i < 30; i++) begin
      check("t1_busy", {31'd0, busy}, {31'd0, (i >= 1) && (i <= WIN)});
      step(i == 0, 1'b1);
    end
    check_drained("t1");

    // Double press inside the window
    t0 = cyc;
    push_evt(2, 31);
    run_seq(0, 10, -1, -1, 40, 1'b1);
    check_drained("t2");

    // Triple press emits immediately; a following press starts a new group
    t0 = cyc;
    push_evt(3, 10);
    push_evt(1, 33);
    run_seq(0, 5, 9, 12, 40, 1'b1);
    check_drained("t3");

    // Press on the expiry cycle is counted instead of timing out
    t0 = cyc;
    push_evt(2, 41);
    run_seq(0, 20, -1, -1, 50, 1'b1);
    check_drained("t4");

    // Backpressure: two single clicks with evt_ready low, then release
    t0 = cyc;
`ifdef CLICK_FIFO_EN
    push_evt(1, 70);
    push_evt(1, 71);
`else
    push_evt(1, 70);
    q_ovf.push_back(61);
`endif
    for (int i = 0; i < 70; i++) begin
      if (i == 30 || i == 65) begin
        check("t5_held_valid", {31'd0, evt_valid}, 32'd1);
        check("t5_held_clicks", {{(32-CW){1'b0}}, evt_clicks}, 32'd1);
      end
      step((i == 0) || (i == 40), 1'b0);
    end
    run_seq(-1, -1, -1, -1, 10, 1'b1);
    check_drained("t5");

    // Reset in the middle of a group
    t0 = cyc;
    run_seq(0, -1, -1, -1, 5, 1'b1);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_cleared("t6_mid_group");
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    run_seq(-1, -1, -1, -1, 40, 1'b1);
    check("t6_busy_after", {31'd0, busy}, 32'd0);
    check_drained("t6");

    // Reset while an event is held
    t0 = cyc;
    run_seq(0, -1, -1, -1, 25, 1'b0);
    check("t7_held_valid", {31'd0, evt_valid}, 32'd1);
    check("t7_held_clicks", {{(32-CW){1'b0}}, evt_clicks}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_cleared("t7_held");
    @(negedge clk);
    cyc++;
    reset_n = 1'b1;
    run_seq(-1, -1, -1, -1, 30, 1'b1);
    check_drained("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
